// File: rtl/i2c_reg_target.sv
// I2C target with an internal byte-wide register file behind an auto-incrementing pointer.
// SCL/SDA are oversampled on clk_i; SDA is open-drain, and the target never stretches SCL.
`timescale 1ns/1ps
module i2c_reg_target #(
   parameter int REG_COUNT = 256
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [6:0] assigned_address_i,
   input  logic       scl_i,
   inout  wire        sda_io
);

   localparam int         PW       = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [7:0] PTR_LAST = 8'(REG_COUNT - 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] ptr_q, ptr_d;
   logic       rw_q, rw_d;
   logic       sda_oe_q, sda_oe_d;
   logic       scl_s1_q, scl_s2_q, scl_prev_q;
   logic       sda_s1_q, sda_s2_q, sda_prev_q;
   logic [7:0] regs_q [REG_COUNT];

   logic       sda_in;
   logic       scl_rise, scl_fall, start_det, stop_det, byte_done, rx_state;
   logic       reg_we;
   logic [7:0] reg_waddr, reg_wdata, rd_byte;

   // Pointer is kept 8 bits wide so out-of-range pointers can be detected when REG_COUNT < 256.
   function automatic logic [7:0] ptr_inc(input logic [7:0] p);
      if (p == PTR_LAST || p == 8'hFF) begin
         return 8'h00;
      end else begin
         return p + 8'd1;
      end
   endfunction

   assign sda_io = sda_oe_q ? 1'b0 : 1'bz;
   assign sda_in = sda_io;

   assign scl_rise  = scl_s2_q & ~scl_prev_q;
   assign scl_fall  = ~scl_s2_q & scl_prev_q;
   assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
   assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
   assign byte_done = scl_fall && (bit_cnt_q == 4'd8);
   assign rx_state  = (state_q == ADDR) || (state_q == REG) || (state_q == WDATA);

   always_comb begin
      rd_byte = 8'h00;
      if ({24'h000000, ptr_q} < 32'(REG_COUNT)) begin
         rd_byte = regs_q[ptr_q[PW-1:0]];
      end else begin
         rd_byte = 8'h00;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      ptr_d     = ptr_q;
      rw_d      = rw_q;
      sda_oe_d  = sda_oe_q;
      reg_we    = 1'b0;
      reg_waddr = ptr_q;
      reg_wdata = shift_q;
      if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
      end else if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
      end else begin
         if (scl_rise && rx_state) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end else begin
            shift_d = shift_q;
         end
         case (state_q)
            ADDR: begin
               if (byte_done) begin
                  bit_cnt_d = 4'd0;
                  if (shift_q[7:1] == assigned_address_i) begin
                     rw_d     = shift_q[0];
                     sda_oe_d = 1'b1;
                     state_d  = ADDR_ACK;
                  end else begin
                     state_d  = IGNORE;
                  end
               end else begin
                  state_d = ADDR;
               end
            end
            REG: begin
               if (byte_done) begin
                  bit_cnt_d = 4'd0;
                  ptr_d     = shift_q;
                  sda_oe_d  = 1'b1;
                  state_d   = REG_ACK;
               end else begin
                  state_d = REG;
               end
            end
            WDATA: begin
               // Out-of-range writes are still ACKed, but the byte is dropped.
               if (byte_done) begin
                  bit_cnt_d = 4'd0;
                  reg_we    = ({24'h000000, ptr_q} < 32'(REG_COUNT));
                  ptr_d     = ptr_inc(ptr_q);
                  sda_oe_d  = 1'b1;
                  state_d   = WDATA_ACK;
               end else begin
                  state_d = WDATA;
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = 4'd0;
                  if (rw_q) begin
                     tx_d     = rd_byte;
                     sda_oe_d = ~rd_byte[7];
                     state_d  = RDATA;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = REG;
                  end
               end else begin
                  state_d = ADDR_ACK;
               end
            end
            REG_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = 1'b0;
                  state_d   = WDATA;
               end else begin
                  state_d = state_q;
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = 1'b0;
                  state_d   = RDATA_ACK;
               end else if (scl_fall) begin
                  tx_d     = {tx_q[6:0], 1'b0};
                  sda_oe_d = ~tx_q[6];
               end else begin
                  state_d = RDATA;
               end
            end
            RDATA_ACK: begin
               // bit_cnt doubles as the "controller ACKed" flag between the 9th rise and fall.
               if (scl_rise) begin
                  if (!sda_s2_q) begin
                     ptr_d     = ptr_inc(ptr_q);
                     bit_cnt_d = 4'd1;
                  end else begin
                     state_d = IGNORE;
                  end
               end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
                  bit_cnt_d = 4'd0;
                  tx_d      = rd_byte;
                  sda_oe_d  = ~rd_byte[7];
                  state_d   = RDATA;
               end else begin
                  state_d = RDATA_ACK;
               end
            end
            IDLE, IGNORE: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               sda_oe_d = 1'b0;
               state_d  = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         scl_s1_q   <= 1'b1;
         scl_s2_q   <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_s1_q   <= 1'b1;
         sda_s2_q   <= 1'b1;
         sda_prev_q <= 1'b1;
         state_q    <= IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         tx_q       <= 8'h00;
         ptr_q      <= 8'h00;
         rw_q       <= 1'b0;
         sda_oe_q   <= 1'b0;
      end else begin
         scl_s1_q   <= scl_i;
         scl_s2_q   <= scl_s1_q;
         scl_prev_q <= scl_s2_q;
         sda_s1_q   <= sda_in;
         sda_s2_q   <= sda_s1_q;
         sda_prev_q <= sda_s2_q;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         sda_oe_q   <= sda_oe_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else if (reg_we) begin
         regs_q[reg_waddr[PW-1:0]] <= reg_wdata;
      end else begin
         regs_q <= regs_q;
      end
   end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C controller plus a byte-array/pointer reference model.
`timescale 1ns/1ps
module tb_i2c_reg_target;

   localparam int Q = 8;   // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n;
   logic       scl;
   logic       m_sda_low;
   logic [6:0] addr = 7'h48;
   wire        sda_w;

   assign sda_w = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda_w);

   always #5 clk = ~clk;

   i2c_reg_target #(.REG_COUNT(256)) dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .assigned_address_i (addr),
      .scl_i              (scl),
      .sda_io             (sda_w)
   );

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  mem [256];
   int unsigned ptr;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      ptr = 0;
   endtask

   task automatic bus_start();
      m_sda_low = 1'b0; wait_clk(Q);
      scl = 1'b1;       wait_clk(Q);
      m_sda_low = 1'b1; wait_clk(Q);
      scl = 1'b0;       wait_clk(Q);
   endtask

   task automatic bus_stop();
      m_sda_low = 1'b1; wait_clk(Q);
      scl = 1'b1;       wait_clk(Q);
      m_sda_low = 1'b0; wait_clk(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         m_sda_low = ~b[i]; wait_clk(Q);
         scl = 1'b1;        wait_clk(2 * Q);
         scl = 1'b0;        wait_clk(Q);
      end
      m_sda_low = 1'b0; wait_clk(Q);
      scl = 1'b1;       wait_clk(Q);
      ack = (sda_w == 1'b0);
      wait_clk(Q);
      scl = 1'b0;       wait_clk(Q);
   endtask

   task automatic recv_byte(output logic [7:0] b, input logic ack_it);
      for (int i = 7; i >= 0; i--) begin
         m_sda_low = 1'b0; wait_clk(Q);
         scl = 1'b1;       wait_clk(Q);
         b[i] = sda_w;     wait_clk(Q);
         scl = 1'b0;       wait_clk(Q);
      end
      m_sda_low = ack_it; wait_clk(Q);
      scl = 1'b1;         wait_clk(2 * Q);
      scl = 1'b0;         wait_clk(2);
      m_sda_low = 1'b0;   wait_clk(Q - 2);
   endtask

   // Full write transaction; n = 0 gives a pointer-only write.
   task automatic write_txn(input string tag, input logic [7:0] p, input logic [7:0] d [4], input int n);
      logic ack;
      bus_start();
      send_byte({addr, 1'b0}, ack); check({tag, "_aack"}, {7'h0, ack}, 8'h01);
      send_byte(p, ack);            check({tag, "_pack"}, {7'h0, ack}, 8'h01);
      ptr = p;
      for (int i = 0; i < n; i++) begin
         send_byte(d[i], ack);      check({tag, "_dack"}, {7'h0, ack}, 8'h01);
         mem[ptr] = d[i];
         ptr = (ptr + 1) % 256;
      end
      bus_stop();
   endtask

   // Read n bytes from the current pointer, ACKing all but the last.
   task automatic read_txn(input string tag, input int n);
      logic       ack;
      logic [7:0] b;
      bus_start();
      send_byte({addr, 1'b1}, ack); check({tag, "_raack"}, {7'h0, ack}, 8'h01);
      for (int i = 0; i < n; i++) begin
         recv_byte(b, i < n - 1);
         check({tag, "_rd"}, b, mem[ptr]);
         if (i < n - 1) ptr = (ptr + 1) % 256;
      end
      check({tag, "_rel"}, {7'h0, sda_w}, 8'h01);
      bus_stop();
   endtask

   task automatic wrong_addr_txn(input string tag, input logic [6:0] a, input logic [7:0] p, input logic [7:0] v);
      logic ack;
      bus_start();
      send_byte({a, 1'b0}, ack); check({tag, "_nack_a"}, {7'h0, ack}, 8'h00);
      send_byte(p, ack);         check({tag, "_nack_p"}, {7'h0, ack}, 8'h00);
      send_byte(v, ack);         check({tag, "_nack_d"}, {7'h0, ack}, 8'h00);
      bus_stop();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] d [4];
      logic       ack;
      logic [6:0] wa;
      int         n;

      rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0;
      model_clear();
      wait_clk(5);
      check("reset_sda", {7'h0, sda_w}, 8'h01);
      rst_n = 1'b1;
      wait_clk(5);
      read_txn("reset_ptr0", 1);

      d = '{8'hB1, 8'h00, 8'h00, 8'h00};
      write_txn("t1_write", 8'h0E, d, 1);
      read_txn("t1_ptr_0f", 1);
      write_txn("t2_ptrw", 8'h0E, d, 0);
      read_txn("t3_read", 1);

      wrong_addr_txn("t4_wrong", 7'h49, 8'h0E, 8'h55);
      write_txn("t4_ptrw", 8'h0E, d, 0);
      read_txn("t4_keep", 1);

      d = '{8'h11, 8'h22, 8'h00, 8'h00};
      write_txn("t5_burst", 8'hFF, d, 2);
      write_txn("t5_ptrw", 8'hFF, d, 0);
      read_txn("t5_read", 2);

      // Reset while the target holds SDA low for bit 6 of 0xB1.
      write_txn("t6_ptrw", 8'h0E, d, 0);
      bus_start();
      send_byte({addr, 1'b1}, ack); check("t6_aack", {7'h0, ack}, 8'h01);
      m_sda_low = 1'b0; wait_clk(Q);
      scl = 1'b1;       wait_clk(Q);
      check("t6_bit7", {7'h0, sda_w}, 8'h01);
      wait_clk(Q);
      scl = 1'b0;       wait_clk(Q);
      check("t6_bit6_low", {7'h0, sda_w}, 8'h00);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("t6_rst_release", {7'h0, sda_w}, 8'h01);
      wait_clk(4);
      rst_n = 1'b1;
      model_clear();
      wait_clk(4);
      bus_stop();
      write_txn("t6_ptrw2", 8'h0E, d, 0);
      read_txn("t6_cleared", 1);

      for (int it = 0; it < 10; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            wa = 7'($urandom_range(0, 127));
            if (wa == addr) wa = 7'h49;
            wrong_addr_txn("rnd_wrong", wa, 8'($urandom), 8'($urandom));
         end else begin
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
            n = $urandom_range(0, 3);
            write_txn("rnd_write", 8'($urandom_range(250, 255) + $urandom_range(0, 3)), d, n);
         end
         write_txn("rnd_ptrw", 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(250, 258)), d, 0);
         read_txn("rnd_read", $urandom_range(1, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
